red_pitaya_exp_trig: RTL

//  Parametrised expansion-connector trigger router. Successor to the fixed 8-pin housekeeping pin logic.
//  Per pin: OR-mask source select over DSP/ASG triggers plus a manual bit, polarity invert, and a

---
 rtl/red_pitaya_exp_trig_if.sv | 29 ++
 rtl/red_pitaya_exp_trig.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_exp_trig_if.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_exp_trig_if
// Brief    : System-bus port bundle for the expansion-connector trigger router.
//            The bus master drives address/data/strobes; the router returns
//            read data, error and acknowledge.
// Revision : 1.0  initial release
// ============================================================================
interface red_pitaya_exp_trig_if;
   logic [31:0] sys_addr;
   logic [31:0] sys_wdata;
   logic [3:0]  sys_sel;
   logic        sys_wen;
   logic        sys_ren;
   logic [31:0] sys_rdata;
   logic        sys_err;
   logic        sys_ack;

   modport master (
      output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
      input  sys_rdata, sys_err, sys_ack
   );

   modport slave (
      input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
      output sys_rdata, sys_err, sys_ack
   );
endinterface
`default_nettype wire

// File: rtl/red_pitaya_exp_trig.sv
`default_nettype none
// ============================================================================
// Module   : red_pitaya_exp_trig
// Brief    : Expansion-connector trigger router. Per pin: OR-mask source
//            select over DSP/ASG triggers plus a manual bit, polarity invert
//            and a programmable pulse stretcher. Pin inputs are synchronised,
//            edge-detected, latched into sticky flags and can raise trig_o.
//            Optional feature macro: EXP_TRIG_CNT_EN (per-pin 32-bit
//            rising-edge counters at 0xC0+4k).
// Revision : 1.0  initial release
// ============================================================================
module red_pitaya_exp_trig #(
   parameter int NPIN = 8,
   parameter int NDSP = 16,
   parameter int NASG = 2,
   parameter int STRW = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NDSP-1:0]      dsp_trig_i,
   input  logic [NASG-1:0]      asg_trig_i,
   input  logic [NPIN-1:0]      exp_dat_i,
   output logic [NPIN-1:0]      exp_dat_o,
   output logic [NPIN-1:0]      exp_dir_o,
   output logic                 trig_o,
   red_pitaya_exp_trig_if.slave bus
);
   localparam int            c_mw       = NDSP + NASG + 1;
   localparam logic [c_mw-1:0] c_mask_rst = {{NASG{1'b0}}, 1'b1, {NDSP{1'b0}}};

   // configuration
   logic [NPIN-1:0]            r_dir;
   logic [NPIN-1:0]            r_manual;
   logic [5:0]                 r_tsel;
   logic [NPIN-1:0][c_mw-1:0]  r_mask;
   logic [NPIN-1:0]            r_inv;
   logic [NPIN-1:0][STRW-1:0]  r_len;
   // output path
   logic [NPIN-1:0]            w_src;
   logic [NPIN-1:0]            r_raw;
   logic [NPIN-1:0]            r_raw_d;
   logic [NPIN-1:0][STRW-1:0]  r_cnt;
   logic [NPIN-1:0]            r_exp_dat;
   // input path
   logic [NPIN-1:0]            r_s1, r_s2, r_s3;
   logic [NPIN-1:0]            w_rise, w_fall, w_clr;
   logic [15:0]                w_rise16, w_fall16;
   logic [NPIN-1:0]            r_sticky;
   logic                       w_trig, r_trig;
   // bus
   logic [17:0]                w_word;
   logic [3:0]                 w_idx;
   logic                       w_sel_cfg, w_sel_len, w_sel_cnt;
   logic [31:0]                w_rdata, r_rdata;
   logic                       r_ack;
   logic                       w_unused_ok;

   // Word-address decode; byte lanes and address bits above 19 play no part.
   assign w_word    = bus.sys_addr[19:2];
   assign w_idx     = w_word[3:0];
   assign w_sel_cfg = (w_word[17:4] == 14'd1);
   assign w_sel_len = (w_word[17:4] == 14'd2);
   assign w_sel_cnt = (w_word[17:4] == 14'd3);
   assign w_unused_ok = ^{bus.sys_sel, bus.sys_addr, bus.sys_wdata, w_sel_cnt};

   // Bus-writable configuration; a write lands on the same edge that raises ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_dir    <= '0;
         r_manual <= '0;
         r_tsel   <= '0;
         r_inv    <= '0;
         for (int k = 0; k < NPIN; k++) begin
            r_mask[k] <= c_mask_rst;
            r_len[k]  <= '0;
         end
      end else if (bus.sys_wen) begin
         if (w_word == 18'd0) r_dir    <= bus.sys_wdata[NPIN-1:0];
         if (w_word == 18'd1) r_manual <= bus.sys_wdata[NPIN-1:0];
         if (w_word == 18'd4) r_tsel   <= bus.sys_wdata[5:0];
         for (int k = 0; k < NPIN; k++) begin
            if (w_sel_cfg && (w_idx == 4'(k))) begin
               r_mask[k] <= bus.sys_wdata[c_mw-1:0];
               r_inv[k]  <= bus.sys_wdata[31];
            end
            if (w_sel_len && (w_idx == 4'(k))) r_len[k] <= bus.sys_wdata[STRW-1:0];
         end
      end
   end

   // Per-pin source: OR over the masked {asg, manual, dsp} trigger vector.
   always_comb begin
      w_src = '0;
      for (int k = 0; k < NPIN; k++)
         w_src[k] = |({asg_trig_i, r_manual[k], dsp_trig_i} & r_mask[k]);
   end

   // Source capture, stretch counter (reloads on every raw rising edge) and pin register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_raw     <= '0;
         r_raw_d   <= '0;
         r_cnt     <= '0;
         r_exp_dat <= '0;
      end else begin
         r_raw   <= w_src;
         r_raw_d <= r_raw;
         for (int k = 0; k < NPIN; k++) begin
            if (r_raw[k] && !r_raw_d[k])
               r_cnt[k] <= r_len[k];
            else if (r_cnt[k] != '0)
               r_cnt[k] <= r_cnt[k] - STRW'(1);
            r_exp_dat[k] <= (r_raw[k] | (r_cnt[k] != '0)) ^ r_inv[k];
         end
      end
   end

   // Two-flop synchroniser plus one history stage for edge detection.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= exp_dat_i;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise = r_s2 & ~r_s3;
   assign w_fall = ~r_s2 & r_s3;
   assign w_clr  = (bus.sys_wen && (w_word == 18'd3)) ? bus.sys_wdata[NPIN-1:0] : '0;

   // Trigger select; vectors padded to 16 so an index past NPIN finds no edge.
   always_comb begin
      w_rise16 = '0;
      w_fall16 = '0;
      w_rise16[NPIN-1:0] = w_rise;
      w_fall16[NPIN-1:0] = w_fall;
      w_trig = (r_tsel[4] & w_rise16[r_tsel[3:0]]) | (r_tsel[5] & w_fall16[r_tsel[3:0]]);
   end

   // Sticky flags (a new edge beats a simultaneous clear) and the trigger pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sticky <= '0;
         r_trig   <= 1'b0;
      end else begin
         r_sticky <= (r_sticky & ~w_clr) | w_rise;
         r_trig   <= w_trig;
      end
   end

`ifdef EXP_TRIG_CNT_EN
   logic [NPIN-1:0][31:0] r_ecnt;

   // Rising-edge counters; a write clears, an edge in that same cycle counts as the first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ecnt <= '0;
      end else begin
         for (int k = 0; k < NPIN; k++) begin
            if (bus.sys_wen && w_sel_cnt && (w_idx == 4'(k)))
               r_ecnt[k] <= {31'd0, w_rise[k]};
            else if (w_rise[k])
               r_ecnt[k] <= r_ecnt[k] + 32'd1;
         end
      end
   end
`endif

   // Read multiplexer; unmapped words and unused bits read as zero.
   always_comb begin
      w_rdata = '0;
      case (w_word)
         18'd0:   w_rdata[NPIN-1:0] = r_dir;
         18'd1:   w_rdata[NPIN-1:0] = r_manual;
         18'd2:   w_rdata[NPIN-1:0] = r_s2;
         18'd3:   w_rdata[NPIN-1:0] = r_sticky;
         18'd4:   w_rdata[5:0]      = r_tsel;
         default: ;
      endcase
      for (int k = 0; k < NPIN; k++) begin
         if (w_sel_cfg && (w_idx == 4'(k))) begin
            w_rdata[c_mw-1:0] = r_mask[k];
            w_rdata[31]       = r_inv[k];
         end
         if (w_sel_len && (w_idx == 4'(k))) w_rdata[STRW-1:0] = r_len[k];
`ifdef EXP_TRIG_CNT_EN
         if (w_sel_cnt && (w_idx == 4'(k))) w_rdata = r_ecnt[k];
`endif
      end
   end

   // Bus response: ack one cycle after any strobe, read data captured alongside.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= bus.sys_wen | bus.sys_ren;
         r_rdata <= bus.sys_ren ? w_rdata : '0;
      end
   end

   assign bus.sys_rdata = r_rdata;
   assign bus.sys_ack   = r_ack;
   assign bus.sys_err   = 1'b0;
   assign exp_dat_o     = r_exp_dat;
   assign exp_dir_o     = r_dir;
   assign trig_o        = r_trig;
endmodule
`default_nettype wire
